// File: rtl/fma_pkg.sv
// -----------------------------------------------------------------------------
// fma_pkg
// Shared types and widths for the fmad mantissa datapath and the shared
// 53x27 multiplier port.
//   MANT_W  mantissa width, hidden bit included
//   HALF_W  width of one half of operand b as sent to the multiplier
//   PP_W    width of one partial product returned by the multiplier
//   PROD_W  width of the full mantissa product
// -----------------------------------------------------------------------------
package fma_pkg;

   localparam int MANT_W = 53;
   localparam int HALF_W = 27;
   localparam int PP_W   = 80;
   localparam int PROD_W = 106;

   // Request side of the shared multiplier port.
   typedef struct packed {
      logic              en;
      logic [MANT_W-1:0] req_in_1;
      logic [HALF_W-1:0] req_in_2;
   } mulit;

   // Response side of the shared multiplier port.
   typedef struct packed {
      logic [PP_W-1:0] out;
   } mulot;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE0,
      ISSUE1,
      WAIT,
      ZERO
   } state_t;

   // Travels alongside each granted issue so the return can be identified.
   // half = 0 for the low half of b, 1 for the high half.
   typedef struct packed {
      logic valid;
      logic half;
   } tag_t;

endpackage

// File: rtl/mul_tag_pipe.sv
// -----------------------------------------------------------------------------
// mul_tag_pipe
// DEPTH-stage shift register of {valid, half} tags that mirrors the latency
// of the shared multiplier, so the tag at the tail lines up with the
// matching mul_out.
// Ports:
//   clk      clock
//   reset    synchronous, active-high clear of every stage
//   tag_in   tag of the issue granted this cycle (valid=0 when none)
//   tag_out  tag whose partial product is on mul_out this cycle
// -----------------------------------------------------------------------------
module mul_tag_pipe
   import fma_pkg::*;
#(
   parameter int DEPTH = 2
)
(
   input  logic clk,
   input  logic reset,
   input  tag_t tag_in,
   output tag_t tag_out
);

   tag_t [DEPTH-1:0] pipe;

   // NOTE: every stage is cleared on reset, not just the head; a surviving
   // valid tag would pair a stale mul_out with the next operation.
   always_ff @(posedge clk) begin
      if (reset) begin
         pipe <= '0;
      end else begin
         pipe[0] <= tag_in;
         for (int i = 1; i < DEPTH; i++) begin
            pipe[i] <= pipe[i-1];
         end
      end
   end

   assign tag_out = pipe[DEPTH-1];

endmodule

// File: rtl/mant_mul_seq.sv
// -----------------------------------------------------------------------------
// mant_mul_seq
// Computes one 53x53 mantissa product through the shared 53x27 multiplier
// port. The low and high halves of b are issued on consecutive granted
// cycles; the two tagged 80-bit partial products are recombined into a
// 106-bit product. A zero operand bypasses the multiplier entirely.
// Parameter:
//   MUL_LAT   cycles from a granted mul_en to its mul_out (1..4)
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req, a, b             start request and operands (taken when req && ready)
//   ready                 high only while idle
//   done, prod            one-cycle completion pulse; product held until next done
//   mul_en, mul_in_1/2    issue request and operands to the shared port
//   mul_gnt               the issue presented this cycle was accepted
//   mul_out               partial product, MUL_LAT cycles after a granted issue
// -----------------------------------------------------------------------------
module mant_mul_seq
   import fma_pkg::*;
#(
   parameter int MUL_LAT = 2
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic [MANT_W-1:0] a,
   input  logic [MANT_W-1:0] b,
   output logic              ready,
   output logic              done,
   output logic [PROD_W-1:0] prod,
   output logic              mul_en,
   output logic [MANT_W-1:0] mul_in_1,
   output logic [HALF_W-1:0] mul_in_2,
   input  logic              mul_gnt,
   input  logic [PP_W-1:0]   mul_out
);

   state_t            state;
   state_t            state_nxt;
   logic [MANT_W-1:0] a_r;
   logic [MANT_W-1:0] b_r;
   logic [PROD_W-1:0] acc;
   mulit              mul_req;
   mulot              mul_rsp;
   tag_t              tag_in;
   tag_t              tag_tail;
   logic              accept;
   logic              ret_lo;
   logic              ret_hi;

   assign accept      = req && (state == IDLE);
   assign mul_rsp.out = mul_out;
   assign ret_lo      = tag_tail.valid && !tag_tail.half;
   assign ret_hi      = tag_tail.valid &&  tag_tail.half;

   // ---------------------------------------------------------------- FSM ---
   // NOTE: sequential state is written with <= so every register in the
   // design updates from pre-edge values, independent of block order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: each always_comb assigns its outputs a default first, so no path
   // through the case leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = ((a == '0) || (b == '0)) ? ZERO : ISSUE0;
         ISSUE0:  if (mul_gnt) state_nxt = ISSUE1;
         ISSUE1:  if (mul_gnt) state_nxt = WAIT;
         WAIT:    if (ret_hi)  state_nxt = IDLE;
         ZERO:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ready   = 1'b0;
      mul_req = '0;
      case (state)
         IDLE:   ready = 1'b1;
         ISSUE0: begin
            mul_req.en       = 1'b1;
            mul_req.req_in_1 = a_r;
            mul_req.req_in_2 = b_r[HALF_W-1:0];
         end
         ISSUE1: begin
            // High half of b is only 26 bits; pad to the port width.
            mul_req.en       = 1'b1;
            mul_req.req_in_1 = a_r;
            mul_req.req_in_2 = {1'b0, b_r[MANT_W-1:HALF_W]};
         end
         default: ;
      endcase
   end

   assign mul_en   = mul_req.en;
   assign mul_in_1 = mul_req.req_in_1;
   assign mul_in_2 = mul_req.req_in_2;

   // ----------------------------------------------------------- operands ---
   // Captured only on acceptance; later changes on a/b are ignored.
   always_ff @(posedge clk) begin
      if (reset) begin
         a_r <= '0;
         b_r <= '0;
      end else if (accept) begin
         a_r <= a;
         b_r <= b;
      end
   end

   // ------------------------------------------------------------ tagging ---
   // A tag enters only when the port actually took the issue, so stalled
   // issue cycles leave bubbles rather than phantom returns.
   assign tag_in.valid = mul_req.en && mul_gnt;
   assign tag_in.half  = (state == ISSUE1);

   mul_tag_pipe #(
      .DEPTH (MUL_LAT)
   ) u_tag_pipe (
      .clk     (clk),
      .reset   (reset),
      .tag_in  (tag_in),
      .tag_out (tag_tail)
   );

   // ---------------------------------------------------------- recombine ---
   // prod = a*b_lo + (a*b_hi << 27); the true product fits in 106 bits.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc  <= '0;
         prod <= '0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == ZERO) begin
            prod <= '0;
            done <= 1'b1;
         end
         if (ret_lo) begin
            acc <= PROD_W'(mul_rsp.out);
         end
         if (ret_hi) begin
            prod <= acc + (PROD_W'(mul_rsp.out) << HALF_W);
            done <= 1'b1;
         end
      end
   end

endmodule
